mult_key_checker: RTL

Self-checking response analyzer for locked multiplier netlists. It accepts operand pairs together with the result returned by a locked (key-gated) WIDTH×WIDTH multiplier under a given key. For each pair it computes the golden product with an internal sequential shift-add multiplier and compares it with the returned result. It then reports per-key mismatch statistics. It is the receiving and judging end of the key-sweep stimulus stream used in gate-level simulation and FPGA-based lock evaluation.

---
 rtl/mult_key_checker.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mult_key_checker.sv
// Response analyzer for locked multipliers: recomputes each product with a
// shift-add multiplier, compares it to the returned result and keeps per-key stats.
module mult_key_checker #(
  parameter int WIDTH     = 8,
  parameter int KEY_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [KEY_WIDTH-1:0]   key_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WIDTH-1:0]       operand1_i,
  input  logic [WIDTH-1:0]       operand2_i,
  input  logic [2*WIDTH-1:0]     result_i,
  input  logic                   done_i,
  output logic                   busy_o,
  output logic                   mismatch_o,
  output logic [2*WIDTH-1:0]     mismatch_bits_o,
  output logic [CNT_WIDTH-1:0]   sample_cnt_o,
  output logic [CNT_WIDTH-1:0]   err_cnt_o,
  output logic [CNT_WIDTH-1:0]   bit_err_cnt_o,
  output logic [KEY_WIDTH-1:0]   key_o,
  output logic                   report_valid_o,
  output logic                   key_correct_o
);

  localparam int PW   = 2 * WIDTH;
  localparam int PCW  = $clog2(PW + 1);
  localparam int SW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SUMW = ((CNT_WIDTH > PCW) ? CNT_WIDTH : PCW) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_MULT,
    S_CMP,
    S_REPORT
  } state_t;

  state_t          state;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]   res_q;
  logic [PW-1:0]   acc;
  logic [SW-1:0]   step;
  logic            done_pend;
  logic [PW-1:0]   diff;
  logic [PCW-1:0]  diff_pop;

  function automatic logic [PCW-1:0] popcount(input logic [PW-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int i = 0; i < PW; i++) n = n + PCW'(v[i]);
    return n;
  endfunction

  // Counters clamp at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [PCW-1:0]       b);
    logic [SUMW-1:0] s;
    s = SUMW'(a) + SUMW'(b);
    if (s > SUMW'(CNT_MAX)) return CNT_MAX;
    return s[CNT_WIDTH-1:0];
  endfunction

  assign diff       = acc ^ res_q;
  assign diff_pop   = popcount(diff);
  assign in_ready_o = (state == S_ACCEPT);
  assign busy_o     = (state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= S_IDLE;
      mcand           <= '0;
      mplier          <= '0;
      res_q           <= '0;
      acc             <= '0;
      step            <= '0;
      done_pend       <= 1'b0;
      mismatch_o      <= 1'b0;
      mismatch_bits_o <= '0;
      sample_cnt_o    <= '0;
      err_cnt_o       <= '0;
      bit_err_cnt_o   <= '0;
      key_o           <= '0;
      report_valid_o  <= 1'b0;
      key_correct_o   <= 1'b0;
    end else begin
      mismatch_o     <= 1'b0;
      report_valid_o <= 1'b0;
      // A new session from any state drops whatever sample was in flight.
      if (start_i) begin
        state           <= S_ACCEPT;
        key_o           <= key_i;
        sample_cnt_o    <= '0;
        err_cnt_o       <= '0;
        bit_err_cnt_o   <= '0;
        mismatch_bits_o <= '0;
        key_correct_o   <= 1'b0;
        done_pend       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_ACCEPT: begin
            if (in_valid_i) begin
              mcand     <= PW'(operand1_i);
              mplier    <= operand2_i;
              res_q     <= result_i;
              acc       <= '0;
              step      <= '0;
              done_pend <= done_i;
              state     <= S_MULT;
            end else if (done_i) begin
              state <= S_REPORT;
            end
          end
          S_MULT: begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            step   <= step + SW'(1);
            if (step == SW'(WIDTH - 1)) state <= S_CMP;
          end
          S_CMP: begin
            mismatch_bits_o <= diff;
            sample_cnt_o    <= sat_add(sample_cnt_o, PCW'(1));
            bit_err_cnt_o   <= sat_add(bit_err_cnt_o, diff_pop);
            if (diff != '0) begin
              err_cnt_o  <= sat_add(err_cnt_o, PCW'(1));
              mismatch_o <= 1'b1;
            end
            state <= done_pend ? S_REPORT : S_ACCEPT;
          end
          S_REPORT: begin
            report_valid_o <= 1'b1;
            key_correct_o  <= (sample_cnt_o != '0) && (err_cnt_o == '0);
            done_pend      <= 1'b0;
            state          <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
